// File: rtl/uart_echo_checker.sv
// uart_echo_checker: 8N1 echo initiator. Sends SEED+i one byte at a time
// and tallies echoes as pass, mismatch/framing error or timeout.
module uart_echo_checker #(
    parameter int         CLKS_PER_BIT   = 868,
    parameter int         NUM_BYTES      = 16,
    parameter logic [7:0] SEED           = 8'h41,
    parameter int         TIMEOUT_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rx,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic [15:0] pass_count,
    output logic [15:0] err_count,
    output logic [15:0] timeout_count,
    output logic [7:0]  last_rcvd
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]   LAST_IDX  = 16'(NUM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_CHECK,
        S_NEXT,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic          accept;
    logic          to_hit;
    logic          send_entry;
    logic          tx_last;
    logic [3:0]    tx_bit;
    logic [CW-1:0] tx_cnt;
    logic [TW-1:0] timer;
    logic [15:0]   idx;
    logic [15:0]   idx_inc;
    logic [7:0]    sent_byte;

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic          rx_active;
    logic          rx_tick;
    logic          rx_done;
    logic          rx_valid;
    logic          frame_err;
    logic [3:0]    rx_bit;
    logic [CW-1:0] rx_cnt;
    logic [7:0]    rx_shift;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign idx_inc    = idx + 16'd1;
    assign sent_byte  = SEED + idx[7:0];
    assign tx_last    = (state == S_SEND) && (tx_bit == 4'd9)
                        && (tx_cnt == BIT_LAST);
    assign send_entry = (state_nx == S_SEND) && (state != S_SEND);
    assign busy       = (state != S_IDLE) && (state != S_DONE);
    assign done       = (state == S_DONE);

    // rx bit 0 is the half-bit start check, 1..8 data, 9 stop
    assign rx_tick = rx_active
                     && (rx_cnt == ((rx_bit == 4'd0) ? HALF_LAST : BIT_LAST));
    assign rx_done = rx_tick && (rx_bit == 4'd9);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        to_hit   = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = S_SEND;
                end
            end
            S_SEND: if (tx_last) state_nx = S_WAIT;
            S_WAIT: begin
                // an echo landing on the timeout cycle still counts
                if (rx_valid || rx_done) begin
                    state_nx = S_CHECK;
                end else if (timer == TO_LAST) begin
                    to_hit   = 1'b1;
                    state_nx = S_NEXT;
                end
            end
            S_CHECK: state_nx = S_NEXT;
            S_NEXT:  state_nx = (idx_inc == LAST_IDX) ? S_DONE : S_SEND;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx            <= 1'b1;
            tx_bit        <= '0;
            tx_cnt        <= '0;
            timer         <= '0;
            idx           <= '0;
            pass_count    <= '0;
            err_count     <= '0;
            timeout_count <= '0;
        end else begin
            if (accept) begin
                idx           <= '0;
                pass_count    <= '0;
                err_count     <= '0;
                timeout_count <= '0;
            end
            if (send_entry) begin
                tx     <= 1'b0;
                tx_bit <= '0;
                tx_cnt <= '0;
            end else if (state == S_SEND) begin
                if (tx_cnt != BIT_LAST) begin
                    tx_cnt <= tx_cnt + CW'(1);
                end else if (tx_bit != 4'd9) begin
                    tx_cnt <= '0;
                    tx_bit <= tx_bit + 4'd1;
                    tx     <= (tx_bit == 4'd8) ? 1'b1 : sent_byte[tx_bit[2:0]];
                end
            end
            if (state == S_SEND)      timer <= '0;
            else if (state == S_WAIT) timer <= timer + TW'(1);
            if (to_hit) timeout_count <= sat_inc(timeout_count);
            if (state == S_CHECK) begin
                if (!frame_err && last_rcvd == sent_byte)
                    pass_count <= sat_inc(pass_count);
                else
                    err_count <= sat_inc(err_count);
            end
            if (state == S_NEXT) idx <= idx_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            rx_active <= 1'b0;
            rx_bit    <= '0;
            rx_cnt    <= '0;
            rx_shift  <= '0;
            last_rcvd <= '0;
            frame_err <= 1'b0;
            rx_valid  <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            if (!rx_active) begin
                if (rx_prev && !rx_sync) begin
                    rx_active <= 1'b1;
                    rx_cnt    <= '0;
                    rx_bit    <= '0;
                end
            end else if (!rx_tick) begin
                rx_cnt <= rx_cnt + CW'(1);
            end else begin
                rx_cnt <= '0;
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd0) begin
                    if (rx_sync) rx_active <= 1'b0;
                end else if (rx_bit == 4'd9) begin
                    rx_active <= 1'b0;
                    last_rcvd <= rx_shift;
                    frame_err <= !rx_sync;
                end else begin
                    rx_shift <= {rx_sync, rx_shift[7:1]};
                end
            end
            // stale or extra echoes are dropped when a new byte goes out
            if (send_entry || state == S_CHECK) rx_valid <= 1'b0;
            else if (rx_done)                   rx_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_echo_checker.sv
// Bench for uart_echo_checker: loopback, timeout, bad echo, framing,
// mid-run reset, restart and randomized echo plans against a count model.
module tb_uart_echo_checker;
    localparam int         CPB      = 16;
    localparam int         NB       = 4;
    localparam logic [7:0] SEED     = 8'h41;
    localparam int         TO       = 400;
    localparam int         WAIT_MAX = TO + 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rx;
    logic        tx;
    logic        busy;
    logic        done;
    logic [15:0] pass_count;
    logic [15:0] err_count;
    logic [15:0] timeout_count;
    logic [7:0]  last_rcvd;

    logic loop_en;
    logic rx_drv;
    int   checks = 0;
    int   errors = 0;

    bit         p_echo[NB];
    logic [7:0] p_mask[NB];
    bit         p_stop[NB];
    int         p_dly[NB];
    bit         p_glitch[NB];
    int         gaps[NB];

    int         exp_pass;
    int         exp_err;
    int         exp_to;
    logic [7:0] exp_last;

    assign rx = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_echo_checker #(
        .CLKS_PER_BIT(CPB),
        .NUM_BYTES(NB),
        .SEED(SEED),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .rx(rx),
        .tx(tx),
        .busy(busy),
        .done(done),
        .pass_count(pass_count),
        .err_count(err_count),
        .timeout_count(timeout_count),
        .last_rcvd(last_rcvd)
    );

    task automatic apply_reset();
        rst     = 1'b1;
        start   = 1'b0;
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic set_plan(input logic [7:0] mask, input int dly);
        for (int i = 0; i < NB; i++) begin
            p_echo[i]   = 1'b1;
            p_mask[i]   = mask;
            p_stop[i]   = 1'b1;
            p_dly[i]    = dly;
            p_glitch[i] = 1'b0;
        end
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic sb);
        for (int w = 0; w < 10; w++) begin
            if (w == 0)      rx_drv = 1'b0;
            else if (w == 9) rx_drv = sb;
            else             rx_drv = b[w-1];
            repeat (CPB) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic echo_byte(input int k);
        int d;
        d = p_dly[k];
        if (p_glitch[k]) begin
            repeat (8) @(negedge clk);
            rx_drv = 1'b0;
            repeat (4) @(negedge clk);
            rx_drv = 1'b1;
            d = d - 12;
        end
        repeat (d) @(negedge clk);
        drive_frame((SEED + 8'(k)) ^ p_mask[k], p_stop[k]);
    endtask

    // Waits for a start bit, then checks every cycle of the 10-bit frame.
    task automatic capture_frame(input logic [7:0] eb, output int gap,
                                 output bit ok);
        int   n;
        int   bad;
        logic e;
        n   = 0;
        bad = 0;
        ok  = 1'b1;
        gap = -1;
        while (tx !== 1'b0 && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            ok = 1'b0;
            $display("FAIL frame_start_%02h: tx=%b after %0d cycles, required 0",
                     eb, tx, n);
            return;
        end
        gap = n - 1;
        for (int c = 0; c < 10 * CPB; c++) begin
            if (c != 0) @(negedge clk);
            if (c < CPB)          e = 1'b0;
            else if (c >= 9 * CPB) e = 1'b1;
            else                   e = eb[(c / CPB) - 1];
            if (tx !== e) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL frame_%02h: %0d bit-cycles wrong, required 0", eb, bad);
        end
    endtask

    task automatic run_session(input bit do_start);
        int gap;
        bit ok;
        int n;
        if (do_start) pulse_start();
        for (int i = 0; i < NB; i++) begin
            capture_frame(SEED + 8'(i), gap, ok);
            gaps[i] = gap;
            if (!ok) return;
            if (!loop_en && p_echo[i]) begin
                fork
                    automatic int k = i;
                    echo_byte(k);
                join_none
            end
        end
        n = 0;
        while (done !== 1'b1 && n < 2 * TO) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_wait: done=%b after %0d cycles, required 1", done, n);
        end
        repeat (2 * CPB) @(negedge clk);
    endtask

    // Count model: every byte is a pass, an error or a timeout.
    task automatic model();
        logic [7:0] sent;
        exp_pass = 0;
        exp_err  = 0;
        exp_to   = 0;
        exp_last = 8'h00;
        for (int i = 0; i < NB; i++) begin
            sent = SEED + 8'(i);
            if (loop_en) begin
                exp_pass++;
                exp_last = sent;
            end else if (!p_echo[i]) begin
                exp_to++;
            end else begin
                exp_last = sent ^ p_mask[i];
                if (p_stop[i] && p_mask[i] == 8'h00) exp_pass++;
                else                                 exp_err++;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (tx !== 1'b1) begin
            errors++; $display("FAIL rst_tx: got %b, required 1", tx);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_busy_done: got %b%b, required 00", busy, done);
        end
        checks++;
        if (pass_count !== 16'd0 || err_count !== 16'd0 || timeout_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_counts: got %0d/%0d/%0d, required 0/0/0",
                     pass_count, err_count, timeout_count);
        end
        checks++;
        if (last_rcvd !== 8'h00) begin
            errors++; $display("FAIL rst_last: got %02h, required 00", last_rcvd);
        end
    endtask

    task automatic test_loopback();
        apply_reset();
        loop_en = 1'b1;
        run_session(1'b1);
        model();
        checks++;
        if (pass_count !== 16'(exp_pass) || err_count !== 16'(exp_err)
            || timeout_count !== 16'(exp_to)) begin
            errors++;
            $display("FAIL loop_counts: got %0d/%0d/%0d, required %0d/%0d/%0d",
                     pass_count, err_count, timeout_count, exp_pass, exp_err, exp_to);
        end
        checks++;
        if (last_rcvd !== exp_last) begin
            errors++; $display("FAIL loop_last: got %02h, required %02h", last_rcvd, exp_last);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL loop_busy: got %b, required 0", busy);
        end
        for (int i = 1; i < NB; i++) begin
            checks++;
            if (gaps[i] != 3) begin
                errors++; $display("FAIL loop_gap%0d: got %0d, required 3", i, gaps[i]);
            end
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        set_plan(8'h00, 50);
        for (int i = 0; i < NB; i++) p_echo[i] = 1'b0;
        run_session(1'b1);
        model();
        checks++;
        if (timeout_count !== 16'(exp_to) || pass_count !== 16'(exp_pass)) begin
            errors++;
            $display("FAIL to_counts: got to=%0d pass=%0d, required to=%0d pass=%0d",
                     timeout_count, pass_count, exp_to, exp_pass);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL to_status: busy/done=%b%b, required 01", busy, done);
        end
        for (int i = 1; i < NB; i++) begin
            checks++;
            if (gaps[i] != TO + 1) begin
                errors++; $display("FAIL to_gap%0d: got %0d, required %0d", i, gaps[i], TO + 1);
            end
        end
    endtask

    task automatic test_bad_echo();
        apply_reset();
        set_plan(8'h01, 50);
        run_session(1'b1);
        model();
        checks++;
        if (err_count !== 16'(exp_err) || pass_count !== 16'(exp_pass)) begin
            errors++;
            $display("FAIL bad_counts: got err=%0d pass=%0d, required err=%0d pass=%0d",
                     err_count, pass_count, exp_err, exp_pass);
        end
        checks++;
        if (last_rcvd !== exp_last) begin
            errors++; $display("FAIL bad_last: got %02h, required %02h", last_rcvd, exp_last);
        end
    endtask

    task automatic test_framing();
        apply_reset();
        set_plan(8'h00, 50);
        p_stop[1]   = 1'b0;
        p_glitch[2] = 1'b1;
        run_session(1'b1);
        model();
        checks++;
        if (err_count !== 16'(exp_err) || pass_count !== 16'(exp_pass)
            || timeout_count !== 16'(exp_to)) begin
            errors++;
            $display("FAIL frm_counts: got %0d/%0d/%0d, required %0d/%0d/%0d",
                     pass_count, err_count, timeout_count, exp_pass, exp_err, exp_to);
        end
    endtask

    task automatic test_rst_midrun();
        int gap;
        bit ok;
        int n;
        apply_reset();
        loop_en = 1'b1;
        pulse_start();
        capture_frame(SEED, gap, ok);
        capture_frame(SEED + 8'd1, gap, ok);
        n = 0;
        while (tx !== 1'b0 && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        repeat (4 * CPB + 4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_status: tx/busy/done=%b%b%b, required 100", tx, busy, done);
        end
        checks++;
        if (pass_count !== 16'd0 || err_count !== 16'd0 || timeout_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_rst_counts: got %0d/%0d/%0d, required 0/0/0",
                     pass_count, err_count, timeout_count);
        end
        repeat (2 * CPB) @(negedge clk);
        run_session(1'b1);
        model();
        checks++;
        if (pass_count !== 16'(exp_pass) || last_rcvd !== exp_last) begin
            errors++;
            $display("FAIL mid_rerun: got pass=%0d last=%02h, required pass=%0d last=%02h",
                     pass_count, last_rcvd, exp_pass, exp_last);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        loop_en = 1'b1;
        fork
            begin
                repeat (250) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join_none
        run_session(1'b1);
        model();
        checks++;
        if (pass_count !== 16'(exp_pass) || err_count !== 16'd0) begin
            errors++;
            $display("FAIL b2b_first: got pass=%0d err=%0d, required pass=%0d err=0",
                     pass_count, err_count, exp_pass);
        end
        pulse_start();
        checks++;
        if (pass_count !== 16'd0 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: pass=%0d done=%b busy=%b, required 0/0/1",
                     pass_count, done, busy);
        end
        run_session(1'b0);
        checks++;
        if (pass_count !== 16'(exp_pass) || err_count !== 16'd0) begin
            errors++;
            $display("FAIL b2b_second: got pass=%0d err=%0d, required pass=%0d err=0",
                     pass_count, err_count, exp_pass);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            apply_reset();
            for (int i = 0; i < NB; i++) begin
                p_echo[i]   = ($urandom_range(0, 4) != 0);
                p_mask[i]   = ($urandom_range(0, 1) != 0) ? 8'h00
                              : 8'($urandom_range(1, 255));
                p_stop[i]   = ($urandom_range(0, 5) != 0);
                p_dly[i]    = $urandom_range(30, 150);
                p_glitch[i] = ($urandom_range(0, 3) == 0);
            end
            run_session(1'b1);
            model();
            checks++;
            if (pass_count !== 16'(exp_pass) || err_count !== 16'(exp_err)
                || timeout_count !== 16'(exp_to)) begin
                errors++;
                $display("FAIL rand%0d_counts: got %0d/%0d/%0d, required %0d/%0d/%0d",
                         k, pass_count, err_count, timeout_count,
                         exp_pass, exp_err, exp_to);
            end
            checks++;
            if (last_rcvd !== exp_last) begin
                errors++;
                $display("FAIL rand%0d_last: got %02h, required %02h", k, last_rcvd, exp_last);
            end
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_timeout();
        test_bad_echo();
        test_framing();
        test_rst_midrun();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_echo_checker.md
Name: uart_echo_checker

Overview:
- Host-side initiator for the UART echo responder. It transmits a deterministic byte sequence over its own 8N1 serializer and deserializes the returned bytes.
- Each echoed byte is compared against the byte sent, and pass, mismatch and timeout counts are accumulated.
- Sits at the far end of the serial link, on a test/bring-up board or in the system testbench, with tx wired to the responder's rx and rx wired to the responder's tx.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4.
- NUM_BYTES, 16, bytes per run (1..65535).
- SEED, 8'h41, first byte sent; byte i = (SEED + i) mod 256.
- TIMEOUT_CYCLES, 20000, max cycles to wait for an echo, counted from the end of the tx stop bit.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a run when not busy
- rx  in  1  serial input from responder (asynchronous)
- tx  out  1  serial output to responder
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  level; high after run completes, until next accepted start or rst
- pass_count  out  16  echoes matching with valid stop bit
- err_count  out  16  mismatched data or framing errors
- timeout_count  out  16  bytes with no echo within TIMEOUT_CYCLES
- last_rcvd  out  8  most recent byte deserialized, whether matched or not

Behaviour:
- Reset values:
  - tx=1, busy=0, done=0.
  - All counts=0, last_rcvd=0.
  - FSM=IDLE, rx engine idle, rx_valid=0.
  - rst mid-operation aborts immediately; tx is high on the cycle after rst is sampled.
- rx input: 2-flop synchronizer before any use. Sampling uses the synchronized signal.
- TX serializer:
  - 10 bits per frame: start(0), d0..d7 LSB first, stop(1).
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - Frame length = 10*CLKS_PER_BIT cycles.
  - tx is registered and idles high.
- RX deserializer:
  - Arms on a 1->0 transition of the synchronized rx.
  - Resamples at CLKS_PER_BIT/2; if rx is high there, it is a false start and the engine returns to idle with no byte.
  - Data bits are sampled at subsequent bit centres (every CLKS_PER_BIT).
  - Stop bit is sampled at its centre. On completion: last_rcvd <= byte, rx_valid <= 1, frame_err <= (stop==0).
  - The engine is ready for a new start edge immediately after stop sampling.
- FSM states:
  - IDLE: start=1 -> clear counts, clear done, index=0, go to SEND. Otherwise hold.
  - SEND:
    - Entry clears rx_valid.
    - First cycle drives the start bit of byte SEED+index.
    - At the end of the stop bit -> WAIT, timeout counter=0.
  - WAIT:
    - rx_valid=1 -> CHECK.
    - Else if timer reaches TIMEOUT_CYCLES-1 -> timeout_count++ -> NEXT.
    - rx_valid is sticky, so an echo completing during the tail of SEND (loopback case) is still consumed.
  - CHECK (1 cycle):
    - If !frame_err and last_rcvd==sent, pass_count++; else err_count++.
    - Clear rx_valid -> NEXT.
  - NEXT (1 cycle):
    - index++.
    - If index==NUM_BYTES -> DONE, else -> SEND.
  - DONE: busy=0, done=1. start=1 -> behaves as in IDLE (restart).
- Only one byte is outstanding at a time; the next byte is never sent before the current CHECK or timeout.
- Counters are 16-bit and saturate at 16'hFFFF, no wrap. Byte values wrap mod 256.
- start is ignored while busy.
- An rx frame arriving in IDLE/DONE updates last_rcvd but affects no count.
- If an rx completion and a timeout occur in the same cycle, the echo wins (CHECK, not timeout).
- An extra byte received in WAIT after CHECK is discarded by the rx_valid clear at the next SEND entry.

Test Plan (CLKS_PER_BIT=16, NUM_BYTES=4, SEED=8'h41, TIMEOUT_CYCLES=400 unless stated):
- Loopback tx->rx, pulse start:
  - tx emits frames 0x41,0x42,0x43,0x44, each 160 cycles, LSB first, bit timing checked.
  - done=1, pass_count=4, err_count=0, timeout_count=0, last_rcvd=0x44.
- rx tied high, pulse start:
  - Each byte waits 400 cycles after its stop bit.
  - timeout_count=4, pass_count=0, done=1, busy low.
- Bench model echoes byte XOR 0x01 after a 50-cycle delay:
  - err_count=4, pass_count=0, last_rcvd=0x45.
- Bench echoes correctly but drives stop bit=0 on the 2nd echo:
  - err_count=1, pass_count=3.
  - A 4-cycle low glitch on rx in WAIT is a false start, ignored.
- Assert rst for 1 cycle during d3 of byte 2:
  - Next cycle tx=1, busy=0, done=0, all counts=0.
  - A later start reruns cleanly to pass_count=4.
- In loopback, pulse start again during the run:
  - The pulse is ignored and the sequence is unchanged.
  - start after done clears counts and reruns to pass_count=4, not 8.
